dmem_axi_bridge: RTL and testbench

Memory-side responder for the data-cache/uncached request port: accepts one strobe/ready request at a time and executes it as a single-beat AXI4-Lite-style read or write. It sits between the data cache's memory port (`m_*` signals) and the SoC interconnect, and returns completion with a one-cycle `m_ready` pulse. It never reorders or overlaps requests; one request is in flight at most.

---
 rtl/dmem_axi_bridge_pkg.sv | 33 +++
 rtl/dmem_axi_bridge_axi_wr_issue.sv | 51 +++++
 rtl/dmem_axi_bridge.sv | 140 ++++++++++++++
 tb/tb_dmem_axi_bridge.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_axi_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | dmem_axi_bridge_pkg : shared state encoding and AXI constants for the bridge
// | Revision: 1.0
// +----------------------------------------------------------------------------
package dmem_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Request size to AXI AxSIZE; the reserved code 3 passes through unchecked.
  function automatic logic [2:0] axi_size(input logic [1:0] sz);
    case (sz)
      SIZE_BYTE: axi_size = 3'd0;
      SIZE_HALF: axi_size = 3'd1;
      SIZE_WORD: axi_size = 3'd2;
      default:   axi_size = 3'd3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_axi_bridge_axi_wr_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | axi_wr_issue : AW/W issue tracker, each channel handshakes independently
// | Revision: 1.0
// +----------------------------------------------------------------------------
module axi_wr_issue (
  input  logic clk,
  input  logic clrn,
  input  logic active_i,
  input  logic awready_i,
  input  logic wready_i,
  output logic awvalid_o,
  output logic wvalid_o,
  output logic done_o
);

  logic aw_done_q, aw_done_d;
  logic w_done_q,  w_done_d;
  logic aw_hs, w_hs;

  assign awvalid_o = active_i & ~aw_done_q;
  assign wvalid_o  = active_i & ~w_done_q;
  assign aw_hs     = awvalid_o & awready_i;
  assign w_hs      = wvalid_o & wready_i;
  // Done as soon as both channels are through, including a same-cycle finish.
  assign done_o    = active_i & (aw_done_q | aw_hs) & (w_done_q | w_hs);

  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (!active_i || done_o) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      aw_done_d = aw_done_q | aw_hs;
      w_done_d  = w_done_q | w_hs;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | dmem_axi_bridge : data-cache memory port to single-beat AXI4-Lite bridge
// | Revision: 1.0
// +----------------------------------------------------------------------------
module dmem_axi_bridge
  import dmem_axi_bridge_pkg::*;
#(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  output logic [31:0]        m_dout,
  input  logic               m_strobe,
  input  logic               m_rw,
  input  logic [3:0]         m_wen,
  input  logic [1:0]         m_size,
  output logic               m_ready,
  output logic               bus_err,
  output logic [A_WIDTH-1:0] araddr,
  output logic [2:0]         arsize,
  output logic               arvalid,
  input  logic               arready,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rvalid,
  output logic               rready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [2:0]         awsize,
  output logic               awvalid,
  input  logic               awready,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wvalid,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready
);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] addr_q,  addr_d;
  logic [31:0]        din_q,   din_d;
  logic [3:0]         wen_q,   wen_d;
  logic [1:0]         size_q,  size_d;
  logic [31:0]        dout_q,  dout_d;
  logic               err_q,   err_d;
  logic               wr_active;
  logic               wr_done;

  assign wr_active = (state_q == ST_WR_REQ);

  axi_wr_issue u_wr_issue (
    .clk       (clk),
    .clrn      (clrn),
    .active_i  (wr_active),
    .awready_i (awready),
    .wready_i  (wready),
    .awvalid_o (awvalid),
    .wvalid_o  (wvalid),
    .done_o    (wr_done)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wen_d   = wen_q;
    size_d  = size_q;
    dout_d  = dout_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (m_strobe) begin
          addr_d  = m_a;
          din_d   = m_din;
          wen_d   = m_wen;
          size_d  = m_size;
          err_d   = 1'b0;
          state_d = m_rw ? ST_WR_REQ : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (arready) state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (rvalid) begin
          dout_d  = rdata;
          err_d   = (rresp != RESP_OKAY);
          state_d = ST_DONE;
        end
      end
      ST_WR_REQ:  if (wr_done) state_d = ST_WR_RESP;
      ST_WR_RESP: begin
        if (bvalid) begin
          err_d   = (bresp != RESP_OKAY);
          state_d = ST_DONE;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      wen_q   <= '0;
      size_q  <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Every output is a decode of state or a request register, never of an input.
  assign arvalid = (state_q == ST_RD_ADDR);
  assign rready  = (state_q == ST_RD_DATA);
  assign bready  = (state_q == ST_WR_RESP);
  assign m_ready = (state_q == ST_DONE);
  assign bus_err = (state_q == ST_DONE) & err_q;
  assign m_dout  = dout_q;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arsize  = axi_size(size_q);
  assign awsize  = axi_size(size_q);
  assign wdata   = din_q;
  assign wstrb   = wen_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_axi_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------
// | tb_dmem_axi_bridge : randomized bench with a memory-model AXI slave
// | Revision: 1.0
// +----------------------------------------------------------------------------
module tb_dmem_axi_bridge;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] m_a, m_din, m_dout;
  logic        m_strobe, m_rw, m_ready, bus_err;
  logic [3:0]  m_wen;
  logic [1:0]  m_size;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic        wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  dmem_axi_bridge #(.A_WIDTH(32)) dut (
    .clk(clk), .clrn(clrn), .m_a(m_a), .m_din(m_din), .m_dout(m_dout),
    .m_strobe(m_strobe), .m_rw(m_rw), .m_wen(m_wen), .m_size(m_size),
    .m_ready(m_ready), .bus_err(bus_err),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_checks, n_errors;
  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];

  int dly_max, ar_fix, r_fix, aw_fix, w_fix, b_fix;
  bit err_plan;

  bit ar_fire, r_fire, aw_fire, w_fire, b_fire;
  bit ar_seen, aw_seen, w_seen, r_pend, b_pend, b_issued;
  int ar_wait, aw_wait, w_wait, r_wait, b_wait;
  logic [31:0] r_addr, ar_addr_s, aw_addr_s, w_data_s;
  logic [2:0]  ar_size_s, aw_size_s;
  logic [3:0]  w_strb_s;

  int ar_cnt, aw_cnt, w_cnt, ready_pulses, n_reqs, last_lat;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [3:0]  cap_wstrb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int fix);
    return (fix >= 0) ? fix : int'($urandom_range(0, dly_max));
  endfunction

  task automatic slave_reset();
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    rdata = 0; rresp = 0; bresp = 0;
    ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
    ar_seen = 0; aw_seen = 0; w_seen = 0; r_pend = 0; b_pend = 0;
    ar_wait = -1; aw_wait = -1; w_wait = -1;
  endtask

  // One slave cycle, evaluated at the falling edge; *_fire flags mark a
  // handshake that completed at the preceding rising edge.
  task automatic slave_step();
    if (ar_fire) begin
      arready = 0; ar_fire = 0; ar_seen = 0; ar_cnt++;
      cap_araddr = ar_addr_s; cap_arsize = ar_size_s;
      r_pend = 1; r_addr = ar_addr_s; r_wait = pick(r_fix);
    end else if (arvalid) begin
      if (ar_seen) begin
        chk("araddr_stable", araddr, ar_addr_s);
        chk("arsize_stable", arsize, ar_size_s);
      end else begin
        ar_seen = 1; ar_addr_s = araddr; ar_size_s = arsize; ar_wait = pick(ar_fix);
      end
      if (ar_wait == 0) arready = 1; else ar_wait--;
    end else if (ar_seen) begin
      chk("arvalid_held", arvalid, 1'b1);
      ar_seen = 0;
    end
    ar_fire = arvalid && arready;

    if (r_fire) begin
      rvalid = 0; r_fire = 0;
    end else if (r_pend) begin
      if (r_wait == 0) begin
        rvalid = 1; rdata = slv_mem[r_addr[5:2]];
        rresp = err_plan ? 2'b10 : 2'b00; r_pend = 0;
      end else r_wait--;
    end
    r_fire = rvalid && rready;

    if (aw_fire) begin
      awready = 0; aw_fire = 0; aw_seen = 0; aw_cnt++;
      cap_awaddr = aw_addr_s; cap_awsize = aw_size_s;
    end else if (awvalid) begin
      if (aw_seen) begin
        chk("awaddr_stable", awaddr, aw_addr_s);
        chk("awsize_stable", awsize, aw_size_s);
      end else begin
        aw_seen = 1; aw_addr_s = awaddr; aw_size_s = awsize; aw_wait = pick(aw_fix);
      end
      if (aw_wait == 0) awready = 1; else aw_wait--;
    end else if (aw_seen) begin
      chk("awvalid_held", awvalid, 1'b1);
      aw_seen = 0;
    end
    aw_fire = awvalid && awready;

    if (w_fire) begin
      wready = 0; w_fire = 0; w_seen = 0; w_cnt++;
      cap_wdata = w_data_s; cap_wstrb = w_strb_s;
    end else if (wvalid) begin
      if (w_seen) begin
        chk("wdata_stable", wdata, w_data_s);
        chk("wstrb_stable", wstrb, w_strb_s);
      end else begin
        w_seen = 1; w_data_s = wdata; w_strb_s = wstrb; w_wait = pick(w_fix);
      end
      if (w_wait == 0) wready = 1; else w_wait--;
    end else if (w_seen) begin
      chk("wvalid_held", wvalid, 1'b1);
      w_seen = 0;
    end
    w_fire = wvalid && wready;

    if (aw_cnt > 0 && w_cnt > 0 && !b_issued) begin
      b_issued = 1; b_pend = 1; b_wait = pick(b_fix);
    end

    if (b_fire) begin
      bvalid = 0; b_fire = 0;
      for (int k = 0; k < 4; k++)
        if (cap_wstrb[k]) slv_mem[cap_awaddr[5:2]][8*k +: 8] = cap_wdata[8*k +: 8];
    end else if (b_pend) begin
      if (b_wait == 0) begin
        bvalid = 1; bresp = err_plan ? 2'b10 : 2'b00; b_pend = 0;
      end else b_wait--;
    end
    b_fire = bvalid && bready;
  endtask

  task automatic tick();
    @(negedge clk);
    if (clrn) slave_step();
    if (m_ready) ready_pulses++;
  endtask

  task automatic do_req(input bit rw, input logic [31:0] addr, input logic [31:0] din,
                        input logic [3:0] wen, input logic [1:0] size, input bit err,
                        input bit keep);
    logic [31:0] exp_rd;
    bit got;
    int lat;
    err_plan = err; ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_issued = 0;
    m_strobe = 1; m_rw = rw; m_a = addr; m_din = din; m_wen = wen; m_size = size;
    n_reqs++;
    exp_rd = ref_mem[addr[5:2]];
    if (rw)
      for (int k = 0; k < 4; k++)
        if (wen[k]) ref_mem[addr[5:2]][8*k +: 8] = din[8*k +: 8];
    got = 0; lat = 0;
    while (!got && lat < 200) begin
      tick(); lat++;
      if (m_ready) got = 1;
    end
    last_lat = lat;
    chk("m_ready_seen", got, 1'b1);
    if (got) begin
      chk("bus_err", bus_err, err);
      if (!rw) begin
        chk("m_dout", m_dout, exp_rd);
        chk("ar_count", ar_cnt, 1);
        chk("aw_count_rd", aw_cnt, 0);
        chk("araddr", cap_araddr, addr);
        chk("arsize", cap_arsize, {1'b0, size});
      end else begin
        chk("aw_count", aw_cnt, 1);
        chk("w_count", w_cnt, 1);
        chk("ar_count_wr", ar_cnt, 0);
        chk("awaddr", cap_awaddr, addr);
        chk("awsize", cap_awsize, {1'b0, size});
        chk("wdata", cap_wdata, din);
        chk("wstrb", cap_wstrb, wen);
      end
    end
    if (!keep) m_strobe = 0;
  endtask

  initial begin
    int p0;
    n_checks = 0; n_errors = 0; ready_pulses = 0; n_reqs = 0;
    dly_max = 0; ar_fix = -1; r_fix = -1; aw_fix = -1; w_fix = -1; b_fix = -1;
    err_plan = 0; b_issued = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    m_strobe = 0; m_rw = 0; m_a = 0; m_din = 0; m_wen = 0; m_size = 0;
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = 32'hA5A5_0000 + 32'(i) * 32'h0101;
      ref_mem[i] = slv_mem[i];
    end
    slave_reset();
    clrn = 0;
    #1;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_m_ready", m_ready, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_m_dout", m_dout, 32'h0);
    tick(); tick();
    clrn = 1;
    tick();

    // Zero-wait read
    slv_mem[0] = 32'hDEAD_BEEF; ref_mem[0] = 32'hDEAD_BEEF;
    do_req(0, 32'h1000_0040, 32'h0, 4'h0, 2'd2, 0, 0);
    chk("rd_latency", last_lat, 3);
    tick();
    chk("rd_pulse_one_cycle", m_ready, 1'b0);

    // Zero-wait write
    do_req(1, 32'h1000_0044, 32'hCAFE_F00D, 4'hF, 2'd2, 0, 0);
    chk("wr_latency", last_lat, 3);
    tick();

    // Byte write, W accepted 3 cycles after AW
    aw_fix = 0; w_fix = 3;
    do_req(1, 32'h1FAF_F003, 32'h0000_0055, 4'b0001, 2'd0, 0, 0);
    chk("wr_split_latency", last_lat, 6);
    aw_fix = -1; w_fix = -1;
    tick();

    // Write-back then refill with strobe held throughout
    p0 = ready_pulses;
    do_req(1, 32'h0000_0080, 32'h1234_5678, 4'hF, 2'd2, 0, 1);
    do_req(0, 32'h0000_1080, 32'h0, 4'h0, 2'd2, 0, 0);
    tick(); tick();
    chk("b2b_pulses", ready_pulses - p0, 2);

    // Error response followed by a clean one
    do_req(0, 32'h1000_0010, 32'h0, 4'h0, 2'd2, 1, 0);
    tick();
    do_req(0, 32'h1000_0014, 32'h0, 4'h0, 2'd2, 0, 0);
    tick();

    // Reset while AR is stalled
    ar_fix = 7;
    m_strobe = 1; m_rw = 0; m_a = 32'h1000_0020; m_size = 2'd2;
    tick(); tick(); tick();
    chk("pre_rst_arvalid", arvalid, 1'b1);
    chk("pre_rst_arready", arready, 1'b0);
    clrn = 0;
    #1;
    chk("mid_rst_arvalid", arvalid, 1'b0);
    chk("mid_rst_m_ready", m_ready, 1'b0);
    chk("mid_rst_awvalid", awvalid, 1'b0);
    chk("mid_rst_wvalid", wvalid, 1'b0);
    chk("mid_rst_m_dout", m_dout, 32'h0);
    slave_reset(); m_strobe = 0; ar_fix = -1;
    tick(); tick();
    clrn = 1;
    tick();
    do_req(0, 32'h1000_0024, 32'h0, 4'h0, 2'd2, 0, 0);
    chk("post_rst_latency", last_lat, 3);
    tick();

    // Randomized traffic
    dly_max = 7;
    p0 = ready_pulses;
    for (int i = 0; i < 1000; i++) begin
      bit rw, keep, err;
      logic [31:0] addr;
      rw   = 1'($urandom_range(0, 1));
      keep = (i != 999) && ($urandom_range(0, 3) == 0);
      err  = ($urandom_range(0, 9) == 0);
      addr = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      do_req(rw, addr, $urandom, 4'($urandom), 2'($urandom_range(0, 2)), err, keep);
      if (!keep) repeat ($urandom_range(0, 2)) tick();
    end
    tick(); tick();
    chk("rand_pulses", ready_pulses - p0, 1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
